// File: rtl/floo_vc_credit_tx_pkg.sv
// Shared types and helpers for the VC credit transmitter.
// The flit layout mirrors the FlooNoC header, which carries the VC id.
package floo_vc_credit_tx_pkg;

  localparam int unsigned VcIdWidth  = 2;
  localparam int unsigned DstIdWidth = 4;
  localparam int unsigned PayloadW   = 16;

  typedef struct packed {
    logic [VcIdWidth-1:0]  vc_id;
    logic [DstIdWidth-1:0] dst_id;
    logic                  last;
  } floo_hdr_t;

  typedef struct packed {
    floo_hdr_t             hdr;
    logic [PayloadW-1:0]   payload;
  } floo_flit_t;

  // Single-step modulo: callers guarantee value < 2*modulus.
  function automatic int unsigned rr_wrap(input int unsigned value, input int unsigned modulus);
    if (value >= modulus) begin
      return value - modulus;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/floo_vc_credit_counter_sat.sv
// Per-VC credit counter: starts full, saturates at Depth on return,
// flags an overflow when a lone return hits a full counter.
module floo_vc_credit_counter_sat #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = $clog2(Depth+1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o,
  output logic             ovf_o
);

  localparam logic [Width-1:0] Full = Width'(Depth);
  localparam logic [Width-1:0] Zero = {Width{1'b0}};
  localparam logic [Width-1:0] One  = {{(Width-1){1'b0}}, 1'b1};

  logic [Width-1:0] count_r;

  assign count_o = count_r;
  assign ovf_o   = inc_i & ~dec_i & (count_r == Full);

  // Simultaneous return and consume cancel out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_r <= Full;
    end else begin
      case ({inc_i, dec_i})
        2'b10: begin
          if (count_r == Full) begin
            count_r <= count_r;
          end else begin
            count_r <= count_r + One;
          end
        end
        2'b01: begin
          if (count_r == Zero) begin
            count_r <= count_r;
          end else begin
            count_r <= count_r - One;
          end
        end
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/floo_vc_credit_tx.sv
// Credit-based VC transmitter: round-robin among VCs holding a flit and a
// credit, stamps the granted VC into the header, registers the flit out.
module floo_vc_credit_tx
  import floo_vc_credit_tx_pkg::*;
#(
  parameter int unsigned NumVC        = 2,
  parameter int unsigned NumVCWidth   = 2,
  parameter int unsigned VCDepth      = 2,
  parameter int unsigned VCDepthWidth = $clog2(VCDepth+1),
  parameter type         flit_t       = floo_flit_t
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumVC-1:0]                      valid_i,
  output logic [NumVC-1:0]                      ready_o,
  input  flit_t                                 data_i [NumVC],
  output logic                                  data_v_o,
  output flit_t                                 data_o,
  input  logic                                  credit_v_i,
  input  logic [NumVCWidth-1:0]                 credit_id_i,
  output logic [NumVC-1:0][VCDepthWidth-1:0]    credit_counter_o,
  output logic                                  idle_o,
  output logic                                  credit_err_o
);

  localparam logic [VCDepthWidth-1:0] DepthVal = VCDepthWidth'(VCDepth);
  localparam logic [VCDepthWidth-1:0] CntZero  = {VCDepthWidth{1'b0}};
  localparam logic [NumVCWidth:0]     NumVcExt = (NumVCWidth+1)'(NumVC);

  logic [NumVC-1:0][VCDepthWidth-1:0] count_s;
  logic [NumVC-1:0]                   inc_s;
  logic [NumVC-1:0]                   ovf_s;
  logic [NumVC-1:0]                   eligible_s;
  logic [NumVC-1:0]                   grant_s;
  logic [NumVCWidth-1:0]              grant_id_s;
  logic                               any_grant_s;
  logic                               id_oob_s;
  logic                               idle_s;
  flit_t                              next_flit_s;

  logic [NumVCWidth-1:0]              rr_r;
  logic                               data_v_r;
  flit_t                              data_r;
  logic                               err_r;

  for (genvar v = 0; v < NumVC; v++) begin : g_cnt
    assign inc_s[v]      = credit_v_i & (credit_id_i == NumVCWidth'(v));
    assign eligible_s[v] = valid_i[v] & (count_s[v] != CntZero) & ~rst_i;

    floo_vc_credit_counter_sat #(
      .Depth (VCDepth),
      .Width (VCDepthWidth)
    ) i_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (inc_s[v]),
      .dec_i   (grant_s[v]),
      .count_o (count_s[v]),
      .ovf_o   (ovf_s[v])
    );
  end

  assign id_oob_s = credit_v_i & ({1'b0, credit_id_i} >= NumVcExt);

  // Round-robin: first eligible VC at or after rr_r, wrapping.
  always_comb begin
    grant_s     = {NumVC{1'b0}};
    grant_id_s  = {NumVCWidth{1'b0}};
    any_grant_s = 1'b0;
    for (int unsigned i = 0; i < NumVC; i++) begin
      for (int unsigned v = 0; v < NumVC; v++) begin
        if (!any_grant_s && eligible_s[v] &&
            (v == rr_wrap(32'(rr_r) + i, NumVC))) begin
          grant_s[v]  = 1'b1;
          grant_id_s  = NumVCWidth'(v);
          any_grant_s = 1'b1;
        end else begin
          any_grant_s = any_grant_s;
        end
      end
    end
  end

  // Granted flit with its VC id overwritten; otherwise hold the last flit.
  always_comb begin
    next_flit_s = data_r;
    for (int unsigned v = 0; v < NumVC; v++) begin
      if (grant_s[v]) begin
        next_flit_s = data_i[v];
      end else begin
        next_flit_s = next_flit_s;
      end
    end
    if (any_grant_s) begin
      next_flit_s.hdr.vc_id = grant_id_s;
    end else begin
      next_flit_s.hdr.vc_id = next_flit_s.hdr.vc_id;
    end
  end

  // Idle once every VC has all credits home and nothing is on the link.
  always_comb begin
    idle_s = ~data_v_r;
    for (int unsigned v = 0; v < NumVC; v++) begin
      if (count_s[v] != DepthVal) begin
        idle_s = 1'b0;
      end else begin
        idle_s = idle_s;
      end
    end
  end

  // Output stage, arbitration pointer and sticky credit error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_v_r <= 1'b0;
      data_r   <= '0;
      rr_r     <= {NumVCWidth{1'b0}};
      err_r    <= 1'b0;
    end else begin
      data_v_r <= any_grant_s;
      data_r   <= next_flit_s;
      if (any_grant_s) begin
        rr_r <= NumVCWidth'(rr_wrap(32'(grant_id_s) + 32'd1, NumVC));
      end else begin
        rr_r <= rr_r;
      end
      err_r <= err_r | id_oob_s | (|ovf_s);
    end
  end

  assign ready_o          = grant_s;
  assign data_v_o         = data_v_r;
  assign data_o           = data_r;
  assign credit_counter_o = count_s;
  assign idle_o           = idle_s;
  assign credit_err_o     = err_r;

endmodule

// File: tb/tb_floo_vc_credit_tx.sv
// Directed bench for floo_vc_credit_tx with a queue-based flit scoreboard.
module tb_floo_vc_credit_tx;
  import floo_vc_credit_tx_pkg::*;

  localparam int unsigned NumVC        = 2;
  localparam int unsigned NumVCWidth   = 2;
  localparam int unsigned VCDepth      = 2;
  localparam int unsigned VCDepthWidth = 2;

  logic                               clk = 1'b0;
  logic                               rst;
  logic [NumVC-1:0]                   valid_i;
  logic [NumVC-1:0]                   ready_o;
  floo_flit_t                         data_i [NumVC];
  logic                               data_v_o;
  floo_flit_t                         data_o;
  logic                               credit_v_i;
  logic [NumVCWidth-1:0]              credit_id_i;
  logic [NumVC-1:0][VCDepthWidth-1:0] credit_counter_o;
  logic                               idle_o;
  logic                               credit_err_o;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;
  floo_flit_t  exp_q[$];
  floo_flit_t  mon_exp;

  always #5 clk = ~clk;

  floo_vc_credit_tx #(
    .NumVC        (NumVC),
    .NumVCWidth   (NumVCWidth),
    .VCDepth      (VCDepth),
    .VCDepthWidth (VCDepthWidth),
    .flit_t       (floo_flit_t)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .data_i           (data_i),
    .data_v_o         (data_v_o),
    .data_o           (data_o),
    .credit_v_i       (credit_v_i),
    .credit_id_i      (credit_id_i),
    .credit_counter_o (credit_counter_o),
    .idle_o           (idle_o),
    .credit_err_o     (credit_err_o)
  );

  function automatic floo_flit_t mk(input logic [1:0] vc, input logic [15:0] pl);
    floo_flit_t f;
    f            = '0;
    f.hdr.vc_id  = vc;
    f.hdr.dst_id = 4'h5;
    f.payload    = pl;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic credit(input logic v, input logic [1:0] id);
    credit_v_i  = v;
    credit_id_i = id;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every flit presented on the link must match the queue head.
  always @(negedge clk) begin
    if (data_v_o === 1'b1) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_flit: got %0h expected none", data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (data_o === mon_exp) pass_cnt++;
        else $display("FAIL flit_out: got %0h expected %0h", data_o, mon_exp);
      end
    end
  end

  initial begin
    rst = 1'b1;
    valid_i = 2'b00;
    data_i[0] = '0;
    data_i[1] = '0;
    credit(1'b0, 2'd0);

    // Reset behaviour
    @(negedge clk);
    check("rst_data_v", 32'(data_v_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cnt0", 32'(credit_counter_o[0]), 32'd2);
    check("idle_cnt1", 32'(credit_counter_o[1]), 32'd2);
    check("idle_idle", 32'(idle_o), 32'd1);
    check("idle_data_v", 32'(data_v_o), 32'd0);
    check("idle_err", 32'(credit_err_o), 32'd0);

    // VC0 held valid for 4 cycles with 2 credits: exactly 2 flits
    for (int k = 0; k < 4; k++) begin
      valid_i   = 2'b01;
      data_i[0] = mk(2'd3, 16'hA000 + 16'(k));
      if (k < 2) exp_q.push_back(mk(2'd0, 16'hA000 + 16'(k)));
      #1;
      check("t1_ready0", 32'(ready_o[0]), (k < 2) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check("t1_ready_stall", 32'(ready_o), 32'd0);
    check("t1_cnt0", 32'(credit_counter_o[0]), 32'd0);
    check("t1_cnt1", 32'(credit_counter_o[1]), 32'd2);
    check("t1_idle", 32'(idle_o), 32'd0);
    valid_i = 2'b00;
    credit(1'b1, 2'd0);
    @(negedge clk);
    @(negedge clk);
    credit(1'b0, 2'd0);
    check("t1_refill", 32'(credit_counter_o[0]), 32'd2);
    pulse_reset();

    // Both VCs valid, one credit back per emitted flit: strict alternation
    for (int k = 0; k < 6; k++) begin
      valid_i   = 2'b11;
      data_i[0] = mk(2'd3, 16'hB000 + 16'(k));
      data_i[1] = mk(2'd3, 16'hC000 + 16'(k));
      if (k > 0) credit(1'b1, 2'((k - 1) % 2));
      else credit(1'b0, 2'd0);
      exp_q.push_back(mk(2'(k % 2), ((k % 2) == 1) ? 16'hC000 + 16'(k) : 16'hB000 + 16'(k)));
      @(negedge clk);
      check("t2_cnt0_pos", 32'(credit_counter_o[0] >= 2'd1), 32'd1);
      check("t2_cnt1_pos", 32'(credit_counter_o[1] >= 2'd1), 32'd1);
    end
    valid_i = 2'b00;
    credit(1'b1, 2'd1);
    @(negedge clk);
    credit(1'b0, 2'd0);
    check("t2_cnt0_end", 32'(credit_counter_o[0]), 32'd2);
    check("t2_cnt1_end", 32'(credit_counter_o[1]), 32'd2);
    check("t2_idle", 32'(idle_o), 32'd1);

    // Drain VC1, then a returned credit unblocks it one cycle later
    for (int k = 0; k < 2; k++) begin
      valid_i   = 2'b10;
      data_i[1] = mk(2'd0, 16'hD000 + 16'(k));
      exp_q.push_back(mk(2'd1, 16'hD000 + 16'(k)));
      @(negedge clk);
    end
    check("t3_cnt1_zero", 32'(credit_counter_o[1]), 32'd0);
    data_i[1] = mk(2'd0, 16'hD002);
    credit(1'b1, 2'd1);
    #1;
    check("t3_ready_blocked", 32'(ready_o), 32'd0);
    @(negedge clk);
    check("t3_cnt1_one", 32'(credit_counter_o[1]), 32'd1);
    credit(1'b0, 2'd0);
    data_i[1] = mk(2'd0, 16'hD003);
    exp_q.push_back(mk(2'd1, 16'hD003));
    #1;
    check("t3_ready_open", 32'(ready_o), 32'd2);
    @(negedge clk);
    valid_i = 2'b00;
    check("t3_flit_v", 32'(data_v_o), 32'd1);
    credit(1'b1, 2'd1);
    @(negedge clk);
    @(negedge clk);
    credit(1'b0, 2'd0);
    check("t3_refill", 32'(credit_counter_o[1]), 32'd2);

    // Same-cycle consume and return on VC0 with one credit left
    valid_i   = 2'b01;
    data_i[0] = mk(2'd2, 16'hE000);
    exp_q.push_back(mk(2'd0, 16'hE000));
    @(negedge clk);
    check("t4_cnt0_one", 32'(credit_counter_o[0]), 32'd1);
    data_i[0] = mk(2'd2, 16'hE001);
    exp_q.push_back(mk(2'd0, 16'hE001));
    credit(1'b1, 2'd0);
    @(negedge clk);
    check("t4_cnt0_same", 32'(credit_counter_o[0]), 32'd1);
    valid_i = 2'b00;
    @(negedge clk);
    credit(1'b0, 2'd0);
    check("t4_cnt0_refill", 32'(credit_counter_o[0]), 32'd2);
    check("t4_err_clear", 32'(credit_err_o), 32'd0);

    // Overflow on a full counter: saturate and set the sticky error
    credit(1'b1, 2'd0);
    @(negedge clk);
    credit(1'b0, 2'd0);
    check("t5_cnt0_sat", 32'(credit_counter_o[0]), 32'd2);
    check("t5_err_set", 32'(credit_err_o), 32'd1);
    repeat (3) @(negedge clk);
    check("t5_err_sticky", 32'(credit_err_o), 32'd1);
    pulse_reset();
    check("t5_err_rst", 32'(credit_err_o), 32'd0);

    // Out-of-range credit id: ignored, error flagged
    credit(1'b1, 2'd2);
    @(negedge clk);
    credit(1'b0, 2'd0);
    check("t6_err_oob", 32'(credit_err_o), 32'd1);
    check("t6_cnt0", 32'(credit_counter_o[0]), 32'd2);
    check("t6_cnt1", 32'(credit_counter_o[1]), 32'd2);
    pulse_reset();

    repeat (2) @(negedge clk);
    check("q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
